// File: rtl/dense_mac_layer1_pkg.sv
// Shared types and constant helpers for the layer-1 dense MAC engine:
// FSM state encoding, saturation bounds and a clog2 constant function.
package dense_mac_layer1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Index widths never drop below one bit so single-entry loops still elaborate.
   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic longint sat_hi(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/dense_mac_layer1_if.sv
// Control/data bundle between the weight loader side and the dense MAC engine.
interface dense_mac_layer1_if #(
   parameter int IN_SIZE  = 1152,
   parameter int OUT_SIZE = 8,
   parameter int W        = 8
);
   logic                         start;
   logic                         weights_ready;
   logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in;
   logic [IN_SIZE*W-1:0]          data_in;
   logic [OUT_SIZE*W-1:0]         data_out;
   logic                         busy;
   logic                         done;

   modport master (
      output start, weights_ready, weights_in, data_in,
      input  data_out, busy, done
   );

   modport slave (
      input  start, weights_ready, weights_in, data_in,
      output data_out, busy, done
   );
endinterface

// File: rtl/dense_mac_layer1_mac_requant_unit.sv
// Signed multiply-accumulate with shift / optional ReLU (DENSE_MAC_RELU_EN) / saturate
// requantization of the running accumulator down to W bits.
module mac_requant_unit
   import dense_mac_layer1_pkg::*;
#(
   parameter int W     = 8,
   parameter int ACC_W = 32,
   parameter int SHIFT = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clr,
   input  logic                i_en,
   input  logic signed [W-1:0] i_w,
   input  logic signed [W-1:0] i_x,
   output logic        [W-1:0] o_q
);
   localparam logic signed [ACC_W-1:0] L_HI = ACC_W'(sat_hi(W));
   localparam logic signed [ACC_W-1:0] L_LO = ACC_W'(sat_lo(W));

   logic signed [ACC_W-1:0] r_acc;
   logic signed [2*W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] w_shr;
   logic signed [ACC_W-1:0] w_pre;

   assign w_prod     = i_w * i_x;
   assign w_prod_ext = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_prod_ext;
      end
   end

   assign w_shr = r_acc >>> SHIFT;

`ifdef DENSE_MAC_RELU_EN
   assign w_pre = w_shr[ACC_W-1] ? '0 : w_shr;
`else
   assign w_pre = w_shr;
`endif

   always_comb begin
      o_q = w_pre[W-1:0];
      if (w_pre > L_HI) begin
         o_q = L_HI[W-1:0];
      end else if (w_pre < L_LO) begin
         o_q = L_LO[W-1:0];
      end
   end

endmodule

// File: rtl/dense_mac_layer1.sv
// Sequential dense layer: OUT_SIZE dot products of length IN_SIZE, one MAC per cycle,
// requantized into a flat output bus. Optional ReLU via `define DENSE_MAC_RELU_EN.
module dense_mac_layer1
   import dense_mac_layer1_pkg::*;
#(
   parameter int IN_SIZE       = 1152,
   parameter int OUT_SIZE      = 8,
   parameter int W             = 8,
   parameter int ACC_W         = 32,
   parameter int SHIFT         = 7,
   parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE
) (
   input logic               clk,
   input logic               rst,
   dense_mac_layer1_if.slave bus
);
   localparam int IN_IDX_W  = clog2(IN_SIZE);
   localparam int OUT_IDX_W = clog2(OUT_SIZE);
   localparam logic [IN_IDX_W-1:0]  IN_LAST  = IN_IDX_W'(IN_SIZE - 1);
   localparam logic [OUT_IDX_W-1:0] OUT_LAST = OUT_IDX_W'(OUT_SIZE - 1);

   state_t                 r_state;
   logic [IN_IDX_W-1:0]    r_in_idx;
   logic [OUT_IDX_W-1:0]   r_out_idx;
   logic [W-1:0]           r_y [OUT_SIZE];
   logic                   r_busy;
   logic                   r_done;

   logic signed [W-1:0]    w_x  [IN_SIZE];
   logic signed [W-1:0]    w_wt [OUT_SIZE][IN_SIZE];
   logic [W-1:0]           w_q;
   logic [OUT_SIZE*W-1:0]  w_dout;
   logic                   w_mac_en;
   logic                   w_mac_clr;

   // Unpack flat buses so the live term is a plain two-level array select.
   genvar gi, gj;
   generate
      for (gi = 0; gi < IN_SIZE; gi++) begin : g_x
         assign w_x[gi] = bus.data_in[gi*W +: W];
      end
      for (gi = 0; gi < OUT_SIZE; gi++) begin : g_row
         for (gj = 0; gj < IN_SIZE; gj++) begin : g_col
            assign w_wt[gi][gj] = bus.weights_in[(gi*IN_SIZE + gj)*W +: W];
         end
      end
   endgenerate

   assign w_mac_en  = (r_state == ST_MAC);
   assign w_mac_clr = !w_mac_en;

   mac_requant_unit #(
      .W     (W),
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_mac_clr),
      .i_en  (w_mac_en),
      .i_w   (w_wt[r_out_idx][r_in_idx]),
      .i_x   (w_x[r_in_idx]),
      .o_q   (w_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_in_idx  <= '0;
         r_out_idx <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < OUT_SIZE; i++) begin
            r_y[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start && bus.weights_ready) begin
                  r_state   <= ST_MAC;
                  r_in_idx  <= '0;
                  r_out_idx <= '0;
                  r_busy    <= 1'b1;
               end
            end
            ST_MAC: begin
               if (r_in_idx == IN_LAST) begin
                  r_state <= ST_STORE;
               end else begin
                  r_in_idx <= r_in_idx + 1'b1;
               end
            end
            ST_STORE: begin
               r_y[r_out_idx] <= w_q;
               r_in_idx       <= '0;
               if (r_out_idx == OUT_LAST) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_out_idx <= r_out_idx + 1'b1;
                  r_state   <= ST_MAC;
               end
            end
            ST_DONE: begin
               // Holding start keeps us here so one request never runs twice.
               if (!bus.start) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_dout = '0;
      for (int i = 0; i < OUT_SIZE; i++) begin
         w_dout[i*W +: W] = r_y[i];
      end
   end

   assign bus.data_out = w_dout;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

// File: tb/tb_dense_mac_layer1.sv
// Directed bench for dense_mac_layer1 at IN_SIZE=4, OUT_SIZE=2: one instance with SHIFT=0
// and one with SHIFT=2 run in lockstep on the same stimulus.
module tb_dense_mac_layer1;
   localparam int IN  = 4;
   localparam int OUT = 2;
   localparam int W   = 8;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic wr;
   logic [IN*OUT*W-1:0] wv;
   logic [IN*W-1:0]     xv;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   int          dcyc;
   logic [15:0] bmask;

   always #5 clk = ~clk;

   dense_mac_layer1_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .W(W)) if_a ();
   dense_mac_layer1_if #(.IN_SIZE(IN), .OUT_SIZE(OUT), .W(W)) if_b ();

   assign if_a.start         = start;
   assign if_a.weights_ready = wr;
   assign if_a.weights_in    = wv;
   assign if_a.data_in       = xv;
   assign if_b.start         = start;
   assign if_b.weights_ready = wr;
   assign if_b.weights_in    = wv;
   assign if_b.data_in       = xv;

   dense_mac_layer1 #(.IN_SIZE(IN), .OUT_SIZE(OUT), .W(W), .ACC_W(32), .SHIFT(0)) u_a (
      .clk (clk), .rst (rst), .bus (if_a.slave)
   );
   dense_mac_layer1 #(.IN_SIZE(IN), .OUT_SIZE(OUT), .W(W), .ACC_W(32), .SHIFT(2)) u_b (
      .clk (clk), .rst (rst), .bus (if_b.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic signed [7:0] ya(input int o);
      return if_a.data_out[o*W +: W];
   endfunction

   function automatic logic signed [7:0] yb(input int o);
      return if_b.data_out[o*W +: W];
   endfunction

   task automatic set_row(input int o, input int a, input int b, input int c, input int d);
      wv[(o*IN+0)*W +: W] = 8'(a);
      wv[(o*IN+1)*W +: W] = 8'(b);
      wv[(o*IN+2)*W +: W] = 8'(c);
      wv[(o*IN+3)*W +: W] = 8'(d);
   endtask

   task automatic set_x(input int a, input int b, input int c, input int d);
      xv[0*W +: W] = 8'(a);
      xv[1*W +: W] = 8'(b);
      xv[2*W +: W] = 8'(c);
      xv[3*W +: W] = 8'(d);
   endtask

   // Cycle k counts edges after the one that precedes start going high.
   task automatic run(input bit hold, output int done_cyc, output logic [15:0] busy_mask);
      done_cyc  = 0;
      busy_mask = '0;
      @(posedge clk); #1;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (!hold) start = 1'b0;
         if (k < 16) busy_mask[k] = if_a.busy;
         if (if_a.done) begin
            done_cyc = k;
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; wr = 1'b0; wv = '0; xv = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_busy", 32'(if_a.busy), 0);
      chk("rst_done", 32'(if_a.done), 0);
      chk("rst_dout", 32'(if_a.data_out), 0);

      // Basic dot product, latency and busy window
      wr = 1'b1;
      set_row(0, 1, 1, 1, 1);
      set_row(1, 1, 1, 1, 1);
      set_x(1, 2, 3, 4);
      run(1'b0, dcyc, bmask);
      $display("txn basic: done_cyc=%0d y0=%0d y1=%0d", dcyc, ya(0), ya(1));
      chk("basic_lat", 32'(dcyc), 11);
      chk("basic_busy", 32'(bmask), 32'h07FE);
      chk("basic_y0", ya(0), 10);
      chk("basic_y1", ya(1), 10);
      chk("basic_b_y0", yb(0), 2);
      @(posedge clk); #1;
      chk("basic_idle_done", 32'(if_a.done), 0);
      chk("basic_idle_hold", ya(1), 10);

      // Start without weights_ready must be ignored
      wr = 1'b0;
      set_row(0, 3, 3, 3, 3);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("nowr_busy0", 32'(if_a.busy), 0);
      repeat (3) @(posedge clk);
      #1;
      $display("txn no_ready: busy=%0d y0=%0d", if_a.busy, ya(0));
      chk("nowr_busy1", 32'(if_a.busy), 0);
      chk("nowr_done", 32'(if_a.done), 0);
      chk("nowr_y0", ya(0), 10);

      // Saturation at both rails
      wr = 1'b1;
      set_row(0, 127, 127, 127, 127);
      set_row(1, -128, -128, -128, -128);
      set_x(127, 127, 127, 127);
      run(1'b0, dcyc, bmask);
      $display("txn saturate: done_cyc=%0d y0=%0d y1=%0d", dcyc, ya(0), ya(1));
      chk("sat_lat", 32'(dcyc), 11);
      chk("sat_y0", ya(0), 127);
`ifdef DENSE_MAC_RELU_EN
      chk("sat_y1", ya(1), 0);
`else
      chk("sat_y1", ya(1), -128);
`endif

      // Reset in the middle of MAC
      set_row(0, 1, 1, 1, 1);
      set_row(1, 1, 1, 1, 1);
      set_x(1, 2, 3, 4);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_busy", 32'(if_a.busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("txn mid_reset: busy=%0d done=%0d dout=%0h", if_a.busy, if_a.done, if_a.data_out);
      chk("mid_rst_busy", 32'(if_a.busy), 0);
      chk("mid_rst_done", 32'(if_a.done), 0);
      chk("mid_rst_dout", 32'(if_a.data_out), 0);
      run(1'b0, dcyc, bmask);
      $display("txn restart: done_cyc=%0d y0=%0d y1=%0d", dcyc, ya(0), ya(1));
      chk("restart_lat", 32'(dcyc), 11);
      chk("restart_y0", ya(0), 10);
      chk("restart_y1", ya(1), 10);

      // Start held through DONE: no second run
      set_row(1, 2, 2, 2, 2);
      run(1'b1, dcyc, bmask);
      $display("txn hold: done_cyc=%0d y0=%0d y1=%0d", dcyc, ya(0), ya(1));
      chk("hold_lat", 32'(dcyc), 11);
      chk("hold_y1", ya(1), 20);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("hold_done", 32'(if_a.done), 1);
         chk("hold_busy", 32'(if_a.busy), 0);
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("hold_release", 32'(if_a.done), 0);
      set_row(1, 1, 2, 3, 4);
      set_x(5, 0, 0, 1);
      run(1'b0, dcyc, bmask);
      $display("txn rerun: done_cyc=%0d y0=%0d y1=%0d", dcyc, ya(0), ya(1));
      chk("rerun_y0", ya(0), 6);
      chk("rerun_y1", ya(1), 9);

      // Arithmetic shift on the SHIFT=2 instance
      set_row(0, 1, 1, 1, 1);
      set_row(1, -1, -2, -3, -4);
      set_x(-3, -3, -3, -3);
      run(1'b0, dcyc, bmask);
      $display("txn shift: a_y0=%0d a_y1=%0d b_y0=%0d b_y1=%0d", ya(0), ya(1), yb(0), yb(1));
      chk("shift_b_lat", 32'(if_b.done), 1);
`ifdef DENSE_MAC_RELU_EN
      chk("shift_a_y0", ya(0), 0);
      chk("shift_b_y0", yb(0), 0);
`else
      chk("shift_a_y0", ya(0), -12);
      chk("shift_b_y0", yb(0), -3);
`endif
      chk("shift_a_y1", ya(1), 30);
      chk("shift_b_y1", yb(1), 7);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dense_mac_layer1.md
Name: dense_mac_layer1

Overview:
- Downstream consumer of the layer-1 weight loaders: a sequential dense-layer compute engine.
- Takes the flat weight vector the loader produces plus a flat input-activation vector. Computes OUT_SIZE dot products of length IN_SIZE, one signed MAC per cycle.
- Requantizes each accumulator to W bits and presents all results on one flat output bus with a level done flag.
- Feeds the next layer's input vector.

Parameters:
- IN_SIZE, 1152, inputs per neuron (dot-product length).
- OUT_SIZE, 8, neurons computed by this block.
- W, 8, width of weights, inputs and outputs (signed two's complement).
- ACC_W, 32, accumulator width; must be >= 2*W + clog2(IN_SIZE).
- SHIFT, 7, arithmetic right shift applied to the final accumulator before saturation.
- TOTAL_WEIGHTS, IN_SIZE*OUT_SIZE, number of weights on the weight bus.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to compute; sampled only in IDLE.
- weights_ready  in  1  loader done flag; start is ignored while low.
- weights_in  in  TOTAL_WEIGHTS*W  flat weights; weight (o,i) at bits [(o*IN_SIZE+i)*W +: W].
- data_in  in  IN_SIZE*W  flat input activations; x[i] at bits [i*W +: W].
- data_out  out  OUT_SIZE*W  flat results; y[o] at bits [o*W +: W].
- busy  out  1  high in MAC and STORE states.
- done  out  1  high while in DONE.

Behaviour:
- Reset: state=IDLE; in_idx=0; out_idx=0; acc=0; data_out=0; busy=0; done=0. Reset mid-computation aborts immediately to this state, and partial results are cleared.
- IDLE → MAC when start && weights_ready. This clears acc, in_idx and out_idx. Start without weights_ready is ignored, with no latching.
- MAC, one cycle per term: acc <= acc + sext(w[out_idx][in_idx]) * sext(x[in_idx]), full signed product, ACC_W wide, no overflow check.
  - If in_idx == IN_SIZE-1, go to STORE.
  - Otherwise in_idx++.
- STORE, one cycle:
  - r = acc >>> SHIFT (arithmetic).
  - Saturate r to [-2^(W-1), 2^(W-1)-1].
  - Write data_out[out_idx*W +: W]; other slots are unchanged.
  - Clear acc and in_idx.
  - If out_idx == OUT_SIZE-1, go to DONE. Otherwise out_idx++ and return to MAC.
- DONE: done=1, data_out stable. Return to IDLE when start is low; stay in DONE while start is held high, so there is no auto-restart.
- Latency: start accepted at edge t gives done high after edge t + OUT_SIZE*(IN_SIZE+1) + 1 (8*1153+1 = 9225 cycles at defaults).
- weights_in and data_in must be held stable from start until done. They are not registered internally.
- start while busy or in DONE is ignored.
- data_out holds its previous results in IDLE. It is overwritten slot-by-slot during the next run and cleared only by rst.

Optional Feature:
- Macro: DENSE_MAC_RELU_EN.
- Defined: in STORE, a negative r is replaced by 0 before saturation, so outputs are in [0, 2^(W-1)-1].
- Undefined: signed saturated output as above; no ReLU logic present.

Decomposition:
- Shared package: state encoding localparams (IDLE, MAC, STORE, DONE), a saturation-bounds helper, and a clog2 constant function.
- One natural sub-module, mac_requant_unit: the signed multiply-accumulate plus shift/ReLU/saturate datapath. It is purely arithmetic with an acc register and clear/enable inputs.
- The FSM and indexing stay in the top.

Test Plan (IN_SIZE=4, OUT_SIZE=2, W=8, SHIFT=0 unless noted):
- All weights 1, x={1,2,3,4}, start with weights_ready=1 → data_out y0=y1=10; done high exactly 11 cycles after the start edge; busy high for cycles 1..10.
- Weights row0={127,127,127,127}, x all 127 → y0 saturates to 127. Row1 all -128, x all 127 → y1=-128, or 0 with DENSE_MAC_RELU_EN.
- SHIFT=2, row0={1,1,1,1}, x={-3,-3,-3,-3} → acc=-12, y0=-3 (arithmetic shift); y0=0 with ReLU.
- start pulsed while weights_ready=0 → stays IDLE, busy=0, data_out unchanged. Later start with weights_ready=1 runs normally.
- rst asserted mid-MAC (cycle 5) → next cycle IDLE, data_out=0, done=0. A restart then gives the correct results and full latency.
- start held high through DONE → done stays high with no second run. Dropping start returns to IDLE; a new start recomputes with updated data_in.
